// File: rtl/tf_gen_ctrl_pkg.sv
// Shared types for the twiddle-factor generator sequencer.
package tf_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD_BASE, LOAD_CONST, DELAY, RUN, UPDATE, DONE
  } state_e;

  // Butterfly reads per group for a given stage; later stages reuse the last size.
  function automatic int grp_size(input int stage, input int g0, input int g1, input int g2);
    case (stage)
      0:       return g0;
      1:       return g1;
      default: return g2;
    endcase
  endfunction

endpackage

// File: rtl/tf_gen_ctrl_bu_counter.sv
// Butterfly-read counters: reads in the current group and reads in the current stage.
module tf_bu_counter #(
  parameter int BU_TOTAL = 512
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr_bu,
  input  logic                        clr_sw,
  input  logic [$clog2(BU_TOTAL)-1:0] grp_last,
  output logic                        grp_end,
  output logic                        stage_end
);

  localparam int BW = $clog2(BU_TOTAL);
  localparam int SW = $clog2(BU_TOTAL + 1);

  logic [BW-1:0] bu_cnt;
  logic [SW-1:0] sw_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bu_cnt <= '0;
      sw_cnt <= '0;
    end else begin
      if (clr_bu)  bu_cnt <= '0;
      else if (en) bu_cnt <= bu_cnt + 1'b1;
      if (clr_sw)  sw_cnt <= '0;
      else if (en) sw_cnt <= sw_cnt + 1'b1;
    end
  end

  assign grp_end   = (bu_cnt == grp_last);
  assign stage_end = (sw_cnt == SW'(BU_TOTAL));

endmodule

// File: rtl/tf_gen_ctrl.sv
// Sequencer for TF_gen: loads base rows and constants from the init ROM, then
// issues per-butterfly read strobes and end-of-group base-update strobes.
module tf_gen_ctrl
  import tf_ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BANK_NUM  = 15,
  parameter int CONST_NUM = 14,
  parameter int K         = 3,
  parameter int BU_TOTAL  = 512,
  parameter int GRP0      = 512,
  parameter int GRP1      = 32,
  parameter int GRP2      = 2,
  parameter int START_DLY = 2
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      bu_ready,
  output logic [$clog2(K)-1:0]      base_addr,
  input  logic [BANK_NUM*DW-1:0]    base_row,
  input  logic [CONST_NUM*DW-1:0]   const_row,
  output logic                      tf_init_base,
  output logic                      tf_init_const,
  output logic                      tf_ren,
  output logic                      tf_wen,
  output logic [DW-1:0]             it_depth_cnt,
  output logic [BANK_NUM*DW-1:0]    tf_base_in,
  output logic [CONST_NUM*DW-1:0]   tf_const_in,
  output logic                      busy,
  output logic                      done
);

  localparam int AW      = $clog2(K);
  localparam int BW      = $clog2(BU_TOTAL);
  localparam int CNT_MAX = (K > START_DLY) ? K : START_DLY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if ((BU_TOTAL % GRP0) != 0 || (BU_TOTAL % GRP1) != 0 || (BU_TOTAL % GRP2) != 0) begin : g_bad_grp
    $error("tf_gen_ctrl: BU_TOTAL must be divisible by every group size");
  end

  state_e          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [AW-1:0]   stage, stage_nx;
  logic            clr_sw, grp_end, stage_end;
  logic [BW-1:0]   grp_last;

  // cnt is the row about to be loaded, so the ROM row lands on the same edge as the strobe.
  assign base_addr = AW'(cnt);
  assign grp_last  = BW'(grp_size(int'(stage), GRP0, GRP1, GRP2) - 1);

  tf_bu_counter #(.BU_TOTAL(BU_TOTAL)) u_bu_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (state == RUN && tf_ren),
    .clr_bu    (state == UPDATE),
    .clr_sw    (clr_sw),
    .grp_last  (grp_last),
    .grp_end   (grp_end),
    .stage_end (stage_end)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    stage_nx = stage;
    clr_sw   = 1'b0;
    case (state)
      IDLE:       if (start) state_nx = LOAD_BASE;
      LOAD_BASE:  if (cnt == CW'(K)) state_nx = LOAD_CONST;
      LOAD_CONST: state_nx = DELAY;
      DELAY:      if (cnt == CW'(START_DLY - 1)) state_nx = RUN;
      RUN:        if (tf_ren && grp_end) state_nx = UPDATE;
      UPDATE: begin
        if (!stage_end) begin
          state_nx = RUN;
        end else if (int'(stage) < K - 1) begin
          stage_nx = stage + 1'b1;
          clr_sw   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        stage_nx = '0;
        clr_sw   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == LOAD_BASE || (state == DELAY && state_nx == DELAY))
      cnt_nx = cnt + 1'b1;
  end

  // Outputs are registered from the next state so they line up with the phase they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      stage         <= '0;
      tf_init_base  <= 1'b0;
      tf_init_const <= 1'b0;
      tf_ren        <= 1'b0;
      tf_wen        <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      it_depth_cnt  <= '0;
      tf_base_in    <= '0;
      tf_const_in   <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      stage         <= stage_nx;
      tf_init_base  <= (state_nx == LOAD_BASE);
      tf_init_const <= (state_nx == LOAD_CONST);
      tf_ren        <= (state_nx == RUN) && bu_ready;
      tf_wen        <= (state_nx == UPDATE);
      done          <= (state_nx == DONE);
      busy          <= (state_nx != IDLE);
      if (state_nx == LOAD_BASE) begin
        tf_base_in   <= base_row;
        it_depth_cnt <= DW'(cnt);
      end
      if (state_nx == LOAD_CONST) begin
        tf_const_in  <= const_row;
        it_depth_cnt <= '0;
      end
      if (state_nx == RUN || state_nx == UPDATE)
        it_depth_cnt <= DW'(stage_nx);
    end
  end

endmodule

// File: tb/tb_tf_gen_ctrl.sv
// Bench for tf_gen_ctrl: captures per-cycle traces and compares them with a
// token-stream model of one NTT run (reads need bu_ready, updates do not).
module tb_tf_gen_ctrl;

  localparam int DW = 32, BANK_NUM = 15, CONST_NUM = 14, K = 3;
  localparam int BU_TOTAL = 512, START_DLY = 2, MAXC = 4200;

  logic clk = 1'b0;
  logic rst, start, start4, bu_ready;
  logic [1:0] base_addr, base_addr4;
  logic [BANK_NUM*DW-1:0] base_row, base_row4, tf_base_in, tf_base_in4;
  logic [CONST_NUM*DW-1:0] const_row, tf_const_in, tf_const_in4;
  logic tf_init_base, tf_init_const, tf_ren, tf_wen, busy, done;
  logic tf_init_base4, tf_init_const4, tf_ren4, tf_wen4, busy4, done4;
  logic [DW-1:0] it_depth_cnt, it_depth_cnt4;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [5:0]    fl;     // {init_base, init_const, ren, wen, done, busy}
    logic [DW-1:0] depth;
    logic [DW-1:0] w14;
  } obs_t;

  obs_t       obs [MAXC];
  bit         rdy [MAXC];
  logic [5:0] efl [MAXC];
  int         edep[MAXC];
  int         ew14[MAXC];
  int         exp_done;
  int         n_ren, n_wen, done_at, first_ren;
  int         wen_by_depth[3];

  always #5 clk = ~clk;

  function automatic logic [BANK_NUM*DW-1:0] rom_row(input logic [1:0] a);
    logic [BANK_NUM*DW-1:0] r;
    r = '0;
    for (int i = 0; i < BANK_NUM; i++) r[i*DW +: DW] = DW'(int'(a) * 16 + i);
    return r;
  endfunction

  assign base_row  = rom_row(base_addr);
  assign base_row4 = rom_row(base_addr4);

  tf_gen_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .bu_ready(bu_ready),
    .base_addr(base_addr), .base_row(base_row), .const_row(const_row),
    .tf_init_base(tf_init_base), .tf_init_const(tf_init_const),
    .tf_ren(tf_ren), .tf_wen(tf_wen), .it_depth_cnt(it_depth_cnt),
    .tf_base_in(tf_base_in), .tf_const_in(tf_const_in),
    .busy(busy), .done(done)
  );

  tf_gen_ctrl #(.GRP2(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bu_ready(bu_ready),
    .base_addr(base_addr4), .base_row(base_row4), .const_row(const_row),
    .tf_init_base(tf_init_base4), .tf_init_const(tf_init_const4),
    .tf_ren(tf_ren4), .tf_wen(tf_wen4), .it_depth_cnt(it_depth_cnt4),
    .tf_base_in(tf_base_in4), .tf_const_in(tf_const_in4),
    .busy(busy4), .done(done4)
  );

  // Start in cycle 0; obs[c] is sampled 1 time unit after edge c, rdy[c] is bu_ready at edge c.
  task automatic capture(input bit use4, input bit rnd, input int s_a, input int s_b,
                         input int abort_at, input int ncyc);
    @(posedge clk); #1;
    if (use4) start4 = 1'b1; else start = 1'b1;
    bu_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      rdy[c] = bu_ready;
      if (use4) begin
        obs[c].fl    = {tf_init_base4, tf_init_const4, tf_ren4, tf_wen4, done4, busy4};
        obs[c].depth = it_depth_cnt4;
        obs[c].w14   = tf_base_in4[14*DW +: DW];
      end else begin
        obs[c].fl    = {tf_init_base, tf_init_const, tf_ren, tf_wen, done, busy};
        obs[c].depth = it_depth_cnt;
        obs[c].w14   = tf_base_in[14*DW +: DW];
      end
      start  = 1'b0;
      start4 = 1'b0;
      if (c == s_a || c == s_b) begin
        if (use4) start4 = 1'b1; else start = 1'b1;
      end
      rst      = (abort_at > 0 && c >= abort_at && c < abort_at + 2);
      bu_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0; start4 = 1'b0; rst = 1'b0; bu_ready = 1'b1;
  endtask

  // Run as a stream of tokens: per stage, BU_TOTAL/grp groups of grp reads then one update.
  task automatic build_model(input bit use4);
    int g[3];
    int c;
    g = '{512, 32, use4 ? 4 : 2};
    for (int i = 0; i < MAXC; i++) begin efl[i] = '0; edep[i] = 0; ew14[i] = 0; end
    c = 1;
    for (int l = 0; l < K; l++) begin
      efl[c] = 6'b100001; edep[c] = l; ew14[c] = l * 16 + 14; c++;
    end
    efl[c] = 6'b010001; c++;
    for (int d = 0; d < START_DLY; d++) begin efl[c] = 6'b000001; c++; end
    for (int s = 0; s < K; s++)
      for (int grp = 0; grp < BU_TOTAL / g[s]; grp++) begin
        for (int rd = 0; rd < g[s] && c < MAXC - 2; ) begin
          if (rdy[c]) begin efl[c] = 6'b001001; edep[c] = s; rd++; end
          else efl[c] = 6'b000001;
          c++;
        end
        if (c < MAXC - 2) begin efl[c] = 6'b000101; edep[c] = s; c++; end
      end
    efl[c] = 6'b000011;
    exp_done = c;
  endtask

  task automatic tally(input int ncyc);
    n_ren = 0; n_wen = 0; done_at = -1; first_ren = -1;
    wen_by_depth = '{0, 0, 0};
    for (int c = 1; c <= ncyc; c++) begin
      if (obs[c].fl[3]) begin n_ren++; if (first_ren < 0) first_ren = c; end
      if (obs[c].fl[2]) begin
        n_wen++;
        if (obs[c].depth < 3) wen_by_depth[obs[c].depth]++;
      end
      if (obs[c].fl[1] && done_at < 0) done_at = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; bu_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({tf_init_base, tf_init_const, tf_ren, tf_wen, done, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000000",
                         {tf_init_base, tf_init_const, tf_ren, tf_wen, done, busy});
    end
    n_chk++;
    if (it_depth_cnt !== '0 || base_addr !== 2'd0) begin
      n_fail++; $display("FAIL reset_depth got %0d/%0d want 0/0", it_depth_cnt, base_addr);
    end
    n_chk++;
    if (tf_base_in !== '0 || tf_const_in !== '0) begin
      n_fail++; $display("FAIL reset_data got nonzero want 0");
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nominal(input string name);
    capture(1'b0, 1'b0, 500, 1816, 0, 1830);
    build_model(1'b0);
    for (int c = 1; c <= 1830; c++) begin
      n_chk++;
      if (obs[c].fl !== efl[c]) begin
        n_fail++; $display("FAIL %s_flags cycle %0d got %b want %b", name, c, obs[c].fl, efl[c]);
      end else if ((efl[c][5:2] != 0) && obs[c].depth !== DW'(edep[c])) begin
        n_fail++; $display("FAIL %s_depth cycle %0d got %0d want %0d", name, c, obs[c].depth, edep[c]);
      end else if (efl[c][5] && obs[c].w14 !== DW'(ew14[c])) begin
        n_fail++; $display("FAIL %s_base14 cycle %0d got %0h want %0h", name, c, obs[c].w14, ew14[c]);
      end
    end
    tally(1830);
    n_chk++;
    if (done_at !== 1816) begin n_fail++; $display("FAIL %s_done_cycle got %0d want 1816", name, done_at); end
    n_chk++;
    if (first_ren !== 7) begin n_fail++; $display("FAIL %s_first_ren got %0d want 7", name, first_ren); end
    n_chk++;
    if (n_ren !== 1536 || n_wen !== 273) begin
      n_fail++; $display("FAIL %s_strobe_counts got %0d/%0d want 1536/273", name, n_ren, n_wen);
    end
    n_chk++;
    if (wen_by_depth[0] !== 1 || wen_by_depth[1] !== 16 || wen_by_depth[2] !== 256) begin
      n_fail++; $display("FAIL %s_wen_per_stage got %0d/%0d/%0d want 1/16/256", name,
                         wen_by_depth[0], wen_by_depth[1], wen_by_depth[2]);
    end
    n_chk++;
    if (tf_const_in !== const_row || tf_base_in[14*DW +: DW] !== 32'h2E) begin
      n_fail++; $display("FAIL %s_data_hold got %0h want %0h (const match %0b)", name,
                         tf_base_in[14*DW +: DW], 32'h2E, tf_const_in === const_row);
    end
  endtask

  task automatic test_stall();
    capture(1'b0, 1'b1, -1, -1, 0, 4000);
    build_model(1'b0);
    n_chk++;
    if (exp_done >= 4000) begin n_fail++; $display("FAIL stall_budget got %0d want <4000", exp_done); end
    for (int c = 1; c <= 4000; c++) begin
      n_chk++;
      if (obs[c].fl !== efl[c]) begin
        n_fail++; $display("FAIL stall_flags cycle %0d got %b want %b", c, obs[c].fl, efl[c]);
      end else if ((efl[c][5:2] != 0) && obs[c].depth !== DW'(edep[c])) begin
        n_fail++; $display("FAIL stall_depth cycle %0d got %0d want %0d", c, obs[c].depth, edep[c]);
      end
    end
    tally(4000);
    n_chk++;
    if (done_at !== exp_done || n_ren !== 1536 || n_wen !== 273) begin
      n_fail++; $display("FAIL stall_summary got done %0d ren %0d wen %0d want %0d/1536/273",
                         done_at, n_ren, n_wen, exp_done);
    end
  endtask

  task automatic test_abort();
    capture(1'b0, 1'b0, -1, -1, 900, 1900);
    build_model(1'b0);
    for (int c = 1; c <= 1900; c++) begin
      n_chk++;
      if (c <= 900) begin
        if (obs[c].fl !== efl[c]) begin
          n_fail++; $display("FAIL abort_pre cycle %0d got %b want %b", c, obs[c].fl, efl[c]);
        end
      end else if (obs[c].fl !== 6'b0 || obs[c].depth !== '0 || obs[c].w14 !== '0) begin
        n_fail++; $display("FAIL abort_post cycle %0d got %b/%0d want 000000/0", c, obs[c].fl, obs[c].depth);
      end
    end
    n_chk++;
    if (tf_base_in !== '0 || tf_const_in !== '0) begin
      n_fail++; $display("FAIL abort_data got nonzero want 0");
    end
    test_nominal("fresh");
  endtask

  task automatic test_grp4();
    capture(1'b1, 1'b0, -1, 1688, 0, 1700);
    build_model(1'b1);
    for (int c = 1; c <= 1700; c++) begin
      n_chk++;
      if (obs[c].fl !== efl[c]) begin
        n_fail++; $display("FAIL grp4_flags cycle %0d got %b want %b", c, obs[c].fl, efl[c]);
      end else if ((efl[c][5:2] != 0) && obs[c].depth !== DW'(edep[c])) begin
        n_fail++; $display("FAIL grp4_depth cycle %0d got %0d want %0d", c, obs[c].depth, edep[c]);
      end
    end
    tally(1700);
    n_chk++;
    if (done_at !== 1688 || wen_by_depth[2] !== 128) begin
      n_fail++; $display("FAIL grp4_summary got done %0d wen2 %0d want 1688/128", done_at, wen_by_depth[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < CONST_NUM; i++) const_row[i*DW +: DW] = $urandom;
    test_reset();
    test_nominal("nominal");
    test_stall();
    test_abort();
    test_grp4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
